// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, byte type and receiver FSM states.
// The matching transmitter imports the same package.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef logic [DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines such as a UART RX pin
// come out of reset in their idle state.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronization into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make meta and q update from the
            // values before the edge, so they form two distinct stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver. Each bit is sampled three times around its
// middle and resolved by majority vote. Received bytes land in a one-entry
// ready/valid buffer; framing errors and overruns are one-cycle pulses.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_rx,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [7:0]       io_out_bits,
    output logic             io_frame_err,
    output logic             io_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Sample points around the middle of each bit, and the last cycle of a bit.
    localparam logic [CW-1:0] SMP_A    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] SMP_B    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] SMP_C    = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic       rx_s;
    rx_state_e  state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic       smp_a;
    logic       smp_b;
    logic       maj;
    uart_byte_t shreg;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (io_rx),
        .q     (rx_s)
    );

    // Majority of the two stored samples and the live third sample.
    assign maj = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    // Receiver FSM, bit counter, shift register and output buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            smp_a        <= 1'b1;
            smp_b        <= 1'b1;
            shreg        <= '0;
            io_out_valid <= 1'b0;
            io_out_bits  <= '0;
            io_frame_err <= 1'b0;
            io_overrun   <= 1'b0;
        end else begin
            io_frame_err <= 1'b0;
            io_overrun   <= 1'b0;

            // NOTE: a later non-blocking assignment in the same block wins, so
            // a load in STOP below overrides this consume and keeps valid high.
            if (io_out_valid && io_out_ready) begin
                io_out_valid <= 1'b0;
            end

            if (cnt == SMP_A) smp_a <= rx_s;
            if (cnt == SMP_B) smp_b <= rx_s;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end

                START: begin
                    if (cnt == SMP_C && maj) begin
                        // Start bit did not hold low: treat as a glitch.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == BIT_LAST) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == SMP_C) shreg <= {maj, shreg[7:1]};
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == IDX_LAST) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt == SMP_C) begin
                        cnt <= '0;
                        if (maj) begin
                            // Return to IDLE half a bit early to absorb baud skew.
                            state <= IDLE;
                            if (!io_out_valid || io_out_ready) begin
                                io_out_valid <= 1'b1;
                                io_out_bits  <= shreg;
                            end else begin
                                io_overrun <= 1'b1;
                            end
                        end else begin
                            state        <= BREAK;
                            io_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                BREAK: begin
                    // Wait for the line to go idle so a held-low line is one error.
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed testbench for uart_rx_os at CLKS_PER_BIT = 16.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_rx = 1'b1;
    logic       io_out_valid;
    logic       io_out_ready = 1'b1;
    logic [7:0] io_out_bits;
    logic       io_frame_err;
    logic       io_overrun;

    int n_checks = 0;
    int n_fails  = 0;

    // Event counters maintained by the monitor.
    int acc_cnt   = 0;
    logic [7:0] acc_byte = 8'h00;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int vld_cyc   = 0;

    int base_acc, base_ferr, base_ovr, base_vld;

    uart_rx_os #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_rx        (io_rx),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_frame_err (io_frame_err),
        .io_overrun   (io_overrun)
    );

    always #5 clock = ~clock;

    // Inputs change 1 ns after posedge; the monitor samples on the negedge.
    always @(negedge clock) begin
        if (io_out_valid && io_out_ready) begin
            acc_cnt++;
            acc_byte = io_out_bits;
        end
        if (io_out_valid) vld_cyc++;
        if (io_frame_err) ferr_cnt++;
        if (io_overrun)   ovr_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Start bit plus eight data bits, LSB first; leaves the last data bit driven.
    task automatic drive_data(input logic [7:0] b);
        io_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            io_rx = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        drive_data(b);
        io_rx = 1'b1;
        tick(CPB);
    endtask

    task automatic snap();
        base_acc  = acc_cnt;
        base_ferr = ferr_cnt;
        base_ovr  = ovr_cnt;
        base_vld  = vld_cyc;
    endtask

    initial begin
        // Reset state.
        tick(4);
        chk("rst_valid", 32'(io_out_valid), 32'd0);
        chk("rst_bits",  32'(io_out_bits),  32'h00);
        chk("rst_ferr",  32'(io_frame_err), 32'd0);
        chk("rst_ovr",   32'(io_overrun),   32'd0);
        chk("rst_state", 32'(dut.state),    32'(IDLE));
        reset = 1'b0;
        tick(3);

        // Single byte with ready held high; load lands 13 edges into stop.
        snap();
        drive_data(8'hA5);
        io_rx = 1'b1;
        tick(12);
        chk("a5_state_stop", 32'(dut.state),    32'(STOP));
        chk("a5_not_yet",    32'(io_out_valid), 32'd0);
        tick(1);
        chk("a5_state_idle", 32'(dut.state),    32'(IDLE));
        chk("a5_valid",      32'(io_out_valid), 32'd1);
        chk("a5_bits",       32'(io_out_bits),  32'hA5);
        tick(1);
        chk("a5_valid_drop", 32'(io_out_valid), 32'd0);
        tick(CPB);
        chk("a5_acc_cnt",    32'(acc_cnt - base_acc),   32'd1);
        chk("a5_acc_byte",   32'(acc_byte),             32'hA5);
        chk("a5_vld_cycles", 32'(vld_cyc - base_vld),   32'd1);
        chk("a5_no_ferr",    32'(ferr_cnt - base_ferr), 32'd0);
        chk("a5_no_ovr",     32'(ovr_cnt - base_ovr),   32'd0);

        // Start glitch, then a clean 0x3C frame.
        snap();
        io_rx = 1'b0;
        tick(3);
        io_rx = 1'b1;
        tick(2 * CPB);
        chk("gl_state",   32'(dut.state),            32'(IDLE));
        chk("gl_no_vld",  32'(vld_cyc - base_vld),   32'd0);
        chk("gl_no_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
        send_frame(8'h3C);
        tick(CPB);
        chk("3c_acc_cnt", 32'(acc_cnt - base_acc), 32'd1);
        chk("3c_byte",    32'(acc_byte),           32'h3C);

        // Framing error with line held low, then recovery with 0x81.
        snap();
        drive_data(8'h55);
        io_rx = 1'b0;
        tick(40);
        chk("fe_pulses", 32'(ferr_cnt - base_ferr), 32'd1);
        chk("fe_no_vld", 32'(vld_cyc - base_vld),   32'd0);
        chk("fe_state",  32'(dut.state),            32'(BREAK));
        io_rx = 1'b1;
        tick(4);
        chk("fe_idle",   32'(dut.state),            32'(IDLE));
        chk("fe_no_acc", 32'(acc_cnt - base_acc),   32'd0);
        send_frame(8'h81);
        tick(CPB);
        chk("81_acc_cnt", 32'(acc_cnt - base_acc), 32'd1);
        chk("81_byte",    32'(acc_byte),           32'h81);
        chk("81_ferr",    32'(ferr_cnt - base_ferr), 32'd1);

        // Overrun: two bytes with ready low keeps the first.
        snap();
        io_out_ready = 1'b0;
        send_frame(8'h11);
        send_frame(8'h22);
        chk("ov_valid", 32'(io_out_valid),        32'd1);
        chk("ov_bits",  32'(io_out_bits),         32'h11);
        chk("ov_pulse", 32'(ovr_cnt - base_ovr),  32'd1);
        io_out_ready = 1'b1;
        tick(CPB);
        chk("ov_acc_cnt", 32'(acc_cnt - base_acc), 32'd1);
        chk("ov_acc_byte", 32'(acc_byte),          32'h11);
        chk("ov_drained", 32'(io_out_valid),       32'd0);

        // Consume and load on the same edge.
        snap();
        io_out_ready = 1'b0;
        send_frame(8'h6B);
        drive_data(8'h9E);
        io_rx = 1'b1;
        tick(12);
        io_out_ready = 1'b1;
        tick(1);
        io_out_ready = 1'b0;
        chk("sim_valid",  32'(io_out_valid),       32'd1);
        chk("sim_bits",   32'(io_out_bits),        32'h9E);
        chk("sim_first",  32'(acc_byte),           32'h6B);
        chk("sim_no_ovr", 32'(ovr_cnt - base_ovr), 32'd0);
        tick(3);
        io_out_ready = 1'b1;
        tick(2);
        chk("sim_second", 32'(acc_byte),           32'h9E);
        chk("sim_acc",    32'(acc_cnt - base_acc), 32'd2);

        // Reset during data bit 4, then a full 0xF0 frame.
        snap();
        io_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            io_rx = i[0];
            tick(CPB);
        end
        io_rx = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        chk("mr_valid", 32'(io_out_valid), 32'd0);
        chk("mr_bits",  32'(io_out_bits),  32'h00);
        chk("mr_state", 32'(dut.state),    32'(IDLE));
        chk("mr_cnt",   32'(dut.cnt),      32'd0);
        reset = 1'b0;
        tick(CPB);
        send_frame(8'hF0);
        tick(CPB);
        chk("mr_acc_cnt", 32'(acc_cnt - base_acc),   32'd1);
        chk("mr_byte",    32'(acc_byte),             32'hF0);
        chk("mr_no_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
        chk("mr_no_ovr",  32'(ovr_cnt - base_ovr),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
